// File: rtl/lsu_engine.sv
// rtl/lsu_engine.sv - RV32I load/store engine: IDLE/READ/WRITE/RESP sequencer over a 1-based word memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word accesses return resp_err).
module lsu_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_out_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             code_ok, misalign, req_bad;
    logic [1:0]       lane;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] shifted, load_val, lane_mask, merged, wr_word;

    always_comb begin
        code_ok = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                         : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad = !code_ok || misalign;
`else
        req_bad = !code_ok;
`endif
    end

    // Without the trap, halfwords drop addr[0] and words drop addr[1:0].
    always_comb begin
        case (f3_q[1:0])
            2'b00:   lane = addr_q[1:0];
            2'b01:   lane = {addr_q[1], 1'b0};
            default: lane = 2'b00;
        endcase
        shamt    = {lane, 3'b000};
        shifted  = mem_out_data >> shamt;
        case (f3_q)
            3'b000:  load_val = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_val = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_val = mem_out_data;
        endcase
        lane_mask = (f3_q[1:0] == 2'b00) ? ({{(WIDTH-8){1'b0}}, 8'hFF} << shamt)
                                         : ({{(WIDTH-16){1'b0}}, 16'hFFFF} << shamt);
        merged    = (word_q & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
        wr_word   = (f3_q[1:0] == 2'b10) ? wdata_q : merged;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                word_d = mem_out_data;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                    rdata_d = load_val;
                    err_d   = 1'b0;
                end
            end
            WRITE: begin
                state_d = RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by rst so an abandoned access never reaches memory.
    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP) && !rst;
    assign resp_rdata     = rst ? '0 : rdata_q;
    assign resp_err       = err_q && !rst;
    assign mem_read_en    = (state_q == READ) && !rst;
    assign mem_write_en   = (state_q == WRITE) && !rst;
    assign mem_addr       = (addr_q >> 2) + WIDTH'(1);
    assign mem_write_data = (state_q == WRITE) ? wr_word : '0;
endmodule

// File: tb/tb_lsu_engine.sv
// tb/tb_lsu_engine.sv - directed self-checking bench for lsu_engine against a 16-word memory model.
module tb_lsu_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_out_data;

    logic [31:0] mem [0:15];
    int          wr_count = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    int checks = 0;
    int errors = 0;
    int lat;
    int wc;
    logic saw_rd, saw_wr, saw_both, saw_resp;

    lsu_engine #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_out_data(mem_out_data)
    );

    always #5 clk = ~clk;

    assign mem_out_data = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr[3:0]] <= mem_write_data;
            last_wa  <= mem_addr;
            last_wd  <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int l);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        saw_rd = 1'b0; saw_wr = 1'b0; saw_both = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_read_en) saw_rd = 1'b1;
            if (mem_write_en) saw_wr = 1'b1;
            if (mem_read_en && mem_write_en) saw_both = 1'b1;
            if (resp_valid) begin
                l = n;
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'b0, req_ready}, 32'd1);

        wc = wr_count;
        do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, lat);
        check("sw_latency", lat, 32'd2);
        check("sw_one_write", wr_count - wc, 32'd1);
        check("sw_mem_addr", last_wa, 32'd3);
        check("sw_no_read", {31'b0, saw_rd}, 32'd0);
        check("sw_rdata_zero", resp_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, lat);
        check("lw_latency", lat, 32'd2);
        check("lw_rdata", resp_rdata, 32'hDEADBEEF);
        check("lw_no_write", {31'b0, saw_wr}, 32'd0);

        do_req(1'b1, 3'b010, 32'h8, 32'h11223344, lat);
        do_req(1'b1, 3'b000, 32'h9, 32'h000000AA, lat);
        check("sb_latency", lat, 32'd3);
        check("sb_wdata", last_wd, 32'h1122AA44);
        check("sb_no_overlap", {31'b0, saw_both}, 32'd0);
        do_req(1'b0, 3'b000, 32'h9, 32'h0, lat);
        check("lb_rdata", resp_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h9, 32'h0, lat);
        check("lbu_rdata", resp_rdata, 32'h000000AA);

        do_req(1'b1, 3'b001, 32'hA, 32'hFFFF5A5A, lat);
        check("sh_wdata", last_wd, 32'h5A5AAA44);
        check("sh_latency", lat, 32'd3);
        do_req(1'b1, 3'b010, 32'h8, 32'h80001234, lat);
        do_req(1'b0, 3'b001, 32'hA, 32'h0, lat);
        check("lh_rdata", resp_rdata, 32'hFFFF8000);
        do_req(1'b0, 3'b101, 32'hA, 32'h0, lat);
        check("lhu_rdata", resp_rdata, 32'h00008000);
        repeat (3) @(negedge clk);
        check("hold_rdata", resp_rdata, 32'h00008000);
        check("hold_valid_low", {31'b0, resp_valid}, 32'd0);

        do_req(1'b1, 3'b010, 32'h4, 32'hCAFEF00D, lat);
        do_req(1'b0, 3'b010, 32'h6, 32'h0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misalign_err", {31'b0, resp_err}, 32'd1);
        check("misalign_latency", lat, 32'd1);
        check("misalign_no_en", {30'b0, saw_rd, saw_wr}, 32'd0);
`else
        check("misalign_err", {31'b0, resp_err}, 32'd0);
        check("misalign_rdata", resp_rdata, 32'hCAFEF00D);
`endif

        wc = wr_count;
        do_req(1'b0, 3'b011, 32'h8, 32'h0, lat);
        check("bad_load_err", {31'b0, resp_err}, 32'd1);
        check("bad_load_latency", lat, 32'd1);
        check("bad_load_no_en", {30'b0, saw_rd, saw_wr}, 32'd0);
        do_req(1'b1, 3'b100, 32'h8, 32'h12345678, lat);
        check("bad_store_err", {31'b0, resp_err}, 32'd1);
        check("bad_store_latency", lat, 32'd1);
        check("bad_store_no_en", {30'b0, saw_rd, saw_wr}, 32'd0);
        check("bad_no_writes", wr_count - wc, 32'd0);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h9; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        saw_wr = 1'b0;
        for (int n = 0; n < 5 && !saw_wr; n++) begin
            @(negedge clk);
            if (mem_write_en) saw_wr = 1'b1;
        end
        check("rst_reach_write", {31'b0, saw_wr}, 32'd1);
        wc = wr_count;
        rst = 1'b1;
        #1;
        check("rst_write_gated", {31'b0, mem_write_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready_after", {31'b0, req_ready}, 32'd1);
        check("rst_rdata_cleared", resp_rdata, 32'h0);
        saw_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("rst_no_resp", {31'b0, saw_resp}, 32'd0);
        check("rst_no_write", wr_count - wc, 32'd0);
        check("rst_mem_intact", mem[3], 32'h80001234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
